load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns MIPS byte/half/word accesses into word-wide memory cycles.
// Sub-word stores are done as a read-modify-write. Loads are sign- or zero-extended.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [31:0] addr_q;

  // Decode of the incoming request, only used in IDLE.
  logic is_load, is_sub_store, is_sw, bad_req;

  // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_load      = 1'b0;
    is_sub_store = 1'b0;
    is_sw        = 1'b0;
    bad_req      = 1'b0;
    case (op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1;      bad_req = addr[0]; end
      OP_LW:         begin is_load = 1'b1;      bad_req = |addr[1:0]; end
      OP_SB:         is_sub_store = 1'b1;
      OP_SH:         begin is_sub_store = 1'b1; bad_req = addr[0]; end
      OP_SW:         begin is_sw = 1'b1;        bad_req = |addr[1:0]; end
      default:       bad_req = 1'b1;
    endcase
  end

  // Lane extraction for loads, from the latched address and opcode.
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;

  always_comb begin
    byte_lane = mem_read_data[8*addr_q[1:0] +: 8];
    half_lane = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (op_q)
      OP_LB:   load_value = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_value = {24'b0, byte_lane};
      OP_LH:   load_value = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_value = {16'b0, half_lane};
      default: load_value = mem_read_data;
    endcase
  end

  // Merge for SB/SH; mem_write_data still holds the latched store data here.
  logic [31:0] merged;

  always_comb begin
    merged = mem_read_data;
    if (op_q == OP_SB)
      merged[8*addr_q[1:0] +: 8] = mem_write_data[7:0];
    else if (addr_q[1])
      merged[31:16] = mem_write_data[15:0];
    else
      merged[15:0] = mem_write_data[15:0];
  end

  assign mem_address = {addr_q[31:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= 32'b0;
      mem_write      <= 1'b0;
      op_q           <= 6'b0;
      addr_q         <= 32'b0;
      mem_write_data <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            op_q           <= op;
            addr_q         <= addr;
            mem_write_data <= wdata;
            busy           <= 1'b1;
            if (bad_req) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (is_load) begin
              state <= RD;
            end else if (is_sw) begin
              state     <= WR;
              mem_write <= 1'b1;
            end else if (is_sub_store) begin
              state <= RMW_RD;
            end
          end
        end
        RD: begin
          rdata <= load_value;
          done  <= 1'b1;
          state <= RESP;
        end
        RMW_RD: begin
          mem_write_data <= merged;
          mem_write      <= 1'b1;
          state          <= WR;
        end
        WR: begin
          mem_write <= 1'b0;
          done      <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory written on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .op             (op),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: combinational read, commit on the falling edge; the bench preloads through load_en.
  logic [31:0] mem [0:63];
  logic        load_en = 1'b0;
  logic [5:0]  load_idx = 6'd0;
  logic [31:0] load_val = 32'd0;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(negedge clk) begin
    if (load_en)        mem[load_idx] <= load_val;
    else if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    load_en  = 1'b1;
    load_idx = idx;
    load_val = val;
    @(negedge clk);
    #1 load_en = 1'b0;
  endtask

  // Issues one request (DUT must be idle) and records what happens, cycle by cycle after the accept edge.
  task automatic run_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic e, output logic [31:0] rd,
                            output int wr_n, output int wr_cyc, output logic [31:0] wr_d);
    lat = -1; e = 1'b0; rd = 32'b0; wr_n = 0; wr_cyc = -1; wr_d = 32'b0;
    op = o; addr = a; wdata = wd; req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) req = 1'b0;
      if (mem_write) begin wr_n++; wr_cyc = k; wr_d = mem_write_data; end
      if (done) begin lat = k; e = err; rd = rdata; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; op = 6'b0; addr = 32'b0; wdata = 32'b0;
    poke(6'd4, 32'h8899AABB);
    poke(6'd5, 32'h0);
    poke(6'd6, 32'h0);
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, mem_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, err, mem_write});
    end
    checks++;
    if (rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got rdata=%h addr=%h wd=%h expected all 0", rdata, mem_address, mem_write_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [5:0]  ops  [5] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [31:0] as   [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
    int lat, wr_n, wr_cyc; logic e; logic [31:0] rd, wr_d;
    for (int i = 0; i < 5; i++) begin
      run_access(ops[i], as[i], 32'h0, lat, e, rd, wr_n, wr_cyc, wr_d);
      checks++;
      if (lat !== 2 || e !== 1'b0 || wr_n !== 0) begin
        errors++; $display("FAIL load_timing[%0d]: got lat=%0d err=%b writes=%0d expected lat=2 err=0 writes=0", i, lat, e, wr_n);
      end
      checks++;
      if (rd !== exps[i]) begin
        errors++; $display("FAIL load_data[%0d]: got %h expected %h", i, rd, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned;
    int lat, wr_n, wr_cyc; logic e; logic [31:0] rd, wr_d;
    run_access(OP_LW, 32'h12, 32'h0, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wr_n !== 0 || rd !== 32'h0000AABB) begin
      errors++; $display("FAIL misaligned_lw: got lat=%0d err=%b writes=%0d rdata=%h expected 1 1 0 0000aabb", lat, e, wr_n, rd);
    end
    run_access(OP_SH, 32'h11, 32'h1234, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wr_n !== 0 || rd !== 32'h0000AABB) begin
      errors++; $display("FAIL misaligned_sh: got lat=%0d err=%b writes=%0d rdata=%h expected 1 1 0 0000aabb", lat, e, wr_n, rd);
    end
    run_access(6'h3F, 32'h10, 32'h0, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 1 || e !== 1'b1 || wr_n !== 0) begin
      errors++; $display("FAIL unknown_op: got lat=%0d err=%b writes=%0d expected 1 1 0", lat, e, wr_n);
    end
  endtask

  task automatic test_reset_in_rmw;
    int dones = 0, wrs = 0;
    op = OP_SH; addr = 32'h12; wdata = 32'h5555; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rmw_reset_idle: got busy=%b mem_write=%b expected 0 0", busy, mem_write);
    end
    for (int k = 0; k < 4; k++) begin
      if (done) dones++;
      if (mem_write) wrs++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 0 || wrs !== 0 || mem[4] !== 32'h8899AABB) begin
      errors++; $display("FAIL rmw_reset_quiet: got dones=%0d writes=%0d mem=%h expected 0 0 8899aabb", dones, wrs, mem[4]);
    end
  endtask

  task automatic test_sub_word_store;
    int lat, wr_n, wr_cyc; logic e; logic [31:0] rd, wr_d;
    run_access(OP_SB, 32'h11, 32'h123456CC, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 3 || e !== 1'b0 || wr_n !== 1 || wr_cyc !== 2 || wr_d !== 32'h8899CCBB) begin
      errors++; $display("FAIL sb_store: got lat=%0d err=%b writes=%0d cyc=%0d data=%h expected 3 0 1 2 8899ccbb",
                         lat, e, wr_n, wr_cyc, wr_d);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL sb_rdata_kept: got %h expected 00000000", rd);
    end
    run_access(OP_LW, 32'h10, 32'h0, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 2 || rd !== 32'h8899CCBB) begin
      errors++; $display("FAIL sb_readback: got lat=%0d rdata=%h expected 2 8899ccbb", lat, rd);
    end
    run_access(OP_SH, 32'h16, 32'hABCD1357, lat, e, rd, wr_n, wr_cyc, wr_d);
    checks++;
    if (lat !== 3 || wr_n !== 1 || wr_cyc !== 2 || wr_d !== 32'h13570000) begin
      errors++; $display("FAIL sh_store: got lat=%0d writes=%0d cyc=%0d data=%h expected 3 1 2 13570000", lat, wr_n, wr_cyc, wr_d);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, dones = 0, wr_n = 0, wr_cyc = -1;
    logic [31:0] rd1 = 32'h0;
    logic busy3 = 1'b1;
    op = OP_LW; addr = 32'h10; wdata = 32'h0; req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin op = OP_SW; addr = 32'h18; wdata = 32'hCAFEF00D; end
      if (k == 3) busy3 = busy;
      if (mem_write) begin wr_n++; wr_cyc = k; end
      if (done) begin
        dones++;
        if (dones == 1) begin d1 = k; rd1 = rdata; end
        else begin d2 = k; req = 1'b0; end
      end
    end
    req = 1'b0;
    checks++;
    if (d1 !== 2 || rd1 !== 32'h8899CCBB || busy3 !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got done=%0d rdata=%h busy3=%b expected 2 8899ccbb 0", d1, rd1, busy3);
    end
    checks++;
    if (d2 !== 5 || dones !== 2 || wr_n !== 1 || wr_cyc !== 4 || mem[6] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_second: got done=%0d dones=%0d writes=%0d cyc=%0d mem=%h expected 5 2 1 4 cafef00d",
                         d2, dones, wr_n, wr_cyc, mem[6]);
    end
  endtask

  task automatic test_reset_in_write;
    op = OP_SW; addr = 32'h14; wdata = 32'hDEADBEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL wr_reset_strobe: got mem_write=%b expected 1", mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_reset_commit: got busy=%b done=%b mem=%h expected 0 0 deadbeef", busy, done, mem[5]);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_misaligned;
    test_reset_in_rmw;
    test_sub_word_store;
    test_back_to_back;
    test_reset_in_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
